// File: rtl/rmii_rx_framer.sv
// RMII receive framer: strips preamble/SFD, packs LSB-first dibits into bytes,
// and marks frame boundaries with sof/eof plus an err qualifier for bad frames.
module rmii_rx_framer #(
  parameter int unsigned PREAMBLE_MIN = 8,
  parameter int unsigned MAX_BYTES    = 1522
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        crsdv,
  input  logic [1:0]  rxd,
  output logic [7:0]  data,
  output logic        valid,
  output logic        sof,
  output logic        eof,
  output logic        err,
  output logic [10:0] byte_count
);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_pre_cnt, w_pre_cnt_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [5:0]  r_shift, w_shift_nxt;
  logic        r_crsdv_prev;
  logic        r_first, w_first_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_valid_nxt, w_sof_nxt, w_eof_nxt, w_err_nxt;
  logic [10:0] w_count_nxt;
  logic        w_end;

  assign w_end = !crsdv && !r_crsdv_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_pre_cnt    <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_crsdv_prev <= 1'b0;
      r_first      <= 1'b0;
      data         <= '0;
      valid        <= 1'b0;
      sof          <= 1'b0;
      eof          <= 1'b0;
      err          <= 1'b0;
      byte_count   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pre_cnt    <= w_pre_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_crsdv_prev <= crsdv;
      r_first      <= w_first_nxt;
      data         <= w_data_nxt;
      valid        <= w_valid_nxt;
      sof          <= w_sof_nxt;
      eof          <= w_eof_nxt;
      err          <= w_err_nxt;
      byte_count   <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pre_cnt_nxt = r_pre_cnt;
    w_idx_nxt     = r_idx;
    w_shift_nxt   = r_shift;
    w_first_nxt   = r_first;
    w_data_nxt    = data;
    w_valid_nxt   = 1'b0;
    w_sof_nxt     = 1'b0;
    w_eof_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    w_count_nxt   = byte_count;

    unique case (r_state)
      S_IDLE: begin
        if (crsdv) begin
          if (rxd == 2'b01) begin
            w_pre_cnt_nxt = 5'd1;
            w_state_nxt   = S_PREAMBLE;
          end else begin
            w_state_nxt   = S_DROP;
          end
        end
      end

      S_PREAMBLE: begin
        if (crsdv) begin
          if (rxd == 2'b01) begin
            if (r_pre_cnt != 5'd31) w_pre_cnt_nxt = r_pre_cnt + 5'd1;
          end else if (rxd == 2'b11 && 32'(r_pre_cnt) >= PREAMBLE_MIN) begin
            w_idx_nxt   = '0;
            w_first_nxt = 1'b1;
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_DROP;
          end
        end else if (w_end) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_DATA: begin
        // byte_count still holds the previous frame until the first byte lands,
        // so the oversize check is gated by r_first.
        if (crsdv) begin
          if (!r_first && byte_count == 11'(MAX_BYTES)) begin
            w_eof_nxt   = 1'b1;
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DROP;
          end else if (r_idx == 2'd3) begin
            w_data_nxt  = {rxd, r_shift};
            w_valid_nxt = 1'b1;
            w_sof_nxt   = r_first;
            w_count_nxt = r_first ? 11'd1 : byte_count + 11'd1;
            w_first_nxt = 1'b0;
            w_idx_nxt   = '0;
          end else begin
            w_shift_nxt = {rxd, r_shift[5:2]};
            w_idx_nxt   = r_idx + 2'd1;
          end
        end else if (w_end) begin
          w_eof_nxt   = 1'b1;
          w_err_nxt   = (r_idx != 2'd0) || r_first;
          w_state_nxt = S_IDLE;
        end
      end

      S_DROP: begin
        if (w_end) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/rmii_rx_framer.md
Name: rmii_rx_framer

Overview:
- Upstream receive stage of the Ethernet bridge. Sits between the PHY RMII pins (eth_crsdv, eth_rxd) and the manta Ethernet packet parser.
- Strips preamble and SFD, assembles LSB-first dibits into bytes and emits a byte stream with start/end-of-frame markers.
- Flags malformed frames (runt preamble, partial final byte, oversize) so the downstream parser discards them.

Parameters:
- PREAMBLE_MIN, 8: minimum count of consecutive 2'b01 dibits required before the SFD 2'b11 dibit is accepted.
- MAX_BYTES, 1522: maximum post-SFD byte count; exceeding it aborts the frame.

Ports:
- clk  in  1  50 MHz RMII reference clock; one dibit per cycle.
- rstn  in  1  asynchronous, active-low reset.
- crsdv  in  1  RMII CRS_DV from PHY.
- rxd  in  2  RMII receive dibit.
- data  out  8  assembled byte; valid only when valid=1.
- valid  out  1  one-cycle strobe per assembled byte.
- sof  out  1  high together with valid on the first byte after the SFD.
- eof  out  1  one-cycle pulse marking end of frame; never coincident with valid.
- err  out  1  qualifies eof; 1 = frame is bad.
- byte_count  out  11  bytes emitted in the frame; held stable from the eof cycle until the next sof.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE.
  - data=0, valid=0, sof=0, eof=0, err=0, byte_count=0.
  - Dibit index=0, preamble counter=0, crsdv_prev=0.
- Inputs are sampled on the rising edge of clk. No input synchronizer; the PHY is clocked from the same clk.
- IDLE:
  - crsdv=1 and rxd=01: preamble counter=1, go to PREAMBLE.
  - crsdv=1 with any other rxd: go to DROP.
- PREAMBLE (evaluated only on cycles with crsdv=1):
  - rxd=01: counter increments, saturating at 31.
  - rxd=11 with counter>=PREAMBLE_MIN: go to DATA with dibit index=0. No output is produced.
  - rxd=11 with counter<PREAMBLE_MIN, or rxd=00/10: go to DROP. No eof (the frame never started).
  - crsdv low for 2 consecutive cycles: return to IDLE silently.
- DATA:
  - A dibit is accepted only on cycles with crsdv=1. Cycles with crsdv=0 are ignored and assembly state is kept.
  - Assembly is LSB-first: dibit k (k=0..3) fills data bits [2k+1:2k].
  - On the 4th accepted dibit: data is registered and valid=1 on the following cycle (latency is 1 cycle after the last dibit sample).
  - sof=1 with the first byte of the frame.
  - byte_count increments with each byte.
- End of frame:
  - Detected when crsdv=0 in two consecutive cycles while in DATA.
  - The cycle after detection: eof=1 for 1 cycle.
  - err=1 if dibit index!=0 (partial byte); the partial byte is discarded and not emitted.
  - err=1 if zero bytes were emitted, with eof still pulsed.
  - Then go to IDLE.
- Oversize:
  - When byte_count has reached MAX_BYTES and a further dibit is accepted: go to DROP.
  - The next cycle: eof=1 with err=1. No further valid strobes; byte_count holds MAX_BYTES.
- DROP: ignore everything until crsdv=0 in two consecutive cycles, then go to IDLE. A second eof is never produced.
- A single crsdv low cycle (glitch or toggle) in any state neither ends nor corrupts the frame.
- valid and eof occur at most once per cycle. When end-of-frame detection coincides with a pending valid, valid fires first and eof follows the next cycle.
- Reset asserted mid-frame:
  - All outputs go to 0 immediately. No eof is emitted.
  - After release the block waits in IDLE. If crsdv is high at release, the current frame is treated as noise: first rxd!=01 sends it to DROP; otherwise a fresh preamble count begins.

Test Plan:
- Frame with 8×01 dibits, then 11, then bytes 0xAB,0xCD,0x12,0x34, then crsdv low 2 cycles -> 4 valid strobes with data AB,CD,12,34 in order; sof only on AB; eof=1 with err=0; byte_count=4.
- Only 5 preamble dibits before 11 (PREAMBLE_MIN=8) -> no valid, no eof; block back in IDLE after crsdv low; a following good frame is received normally.
- Good preamble/SFD, 2 bytes, then 2 extra dibits, then end -> 2 valid strobes; eof with err=1; byte_count=2.
- Single crsdv low cycle inserted mid-byte in a 3-byte frame (0x5A,0xA5,0xFF) -> bytes still correct; exactly one eof, err=0.
- MAX_BYTES=4, 6-byte frame -> 4 valid strobes; eof with err=1 the cycle after the 5th-byte dibit is accepted; byte_count=4; nothing further until crsdv low then IDLE.
- rstn pulsed low during byte 2 of a frame -> outputs 0 asynchronously, no eof; next full frame received correctly with byte_count starting from 1.
